// File: rtl/amplitude_peak_window.sv
// rtl/amplitude_peak_window.sv - windowed peak |sample| tracker feeding the AGC divider
// Emits a one-cycle (reference, amplitude) pair at the end of each window of accepted samples.
module amplitude_peak_window #(
    parameter int SAMPLE_DATA_SIZE    = 16,
    parameter int AMPLITUDE_DATA_SIZE = 16,
    parameter int WINDOW_LOG2         = 10
) (
    input  logic                           i_clock,
    input  logic                           i_reset_n,
    input  logic                           i_enable,
    input  logic [SAMPLE_DATA_SIZE-1:0]    i_sample,
    input  logic                           i_sample_valid,
    input  logic [AMPLITUDE_DATA_SIZE-1:0] i_reference,
    output logic [AMPLITUDE_DATA_SIZE-1:0] o_amplitude,
    output logic [AMPLITUDE_DATA_SIZE-1:0] o_reference,
    output logic                           o_valid,
    output logic [WINDOW_LOG2-1:0]         o_window_count
);

    localparam int SW = SAMPLE_DATA_SIZE;
    localparam int AW = AMPLITUDE_DATA_SIZE;
    localparam int WL = WINDOW_LOG2;

    localparam logic [SW-1:0] MOST_NEG = {1'b1, {(SW-1){1'b0}}};
    localparam logic [AW-1:0] AMP_ONE  = AW'(1);

    typedef enum logic {
        ST_TRACK = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   abs_q, abs_d;
    logic            abs_valid_q, abs_valid_d;
    logic [AW-1:0]   peak_q, peak_d;
    logic [WL-1:0]   count_q, count_d;
    logic [AW-1:0]   amp_q, amp_d;
    logic [AW-1:0]   ref_q, ref_d;
    logic            valid_q, valid_d;

    logic [SW-1:0]   mag;
    logic [AW-1:0]   peak_max;

    // Stage 1: magnitude; the most-negative code has no positive twin, so clamp it.
    always_comb begin
        mag   = i_sample;
        abs_d = '0;
        if (i_sample[SW-1]) begin
            if (i_sample == MOST_NEG) begin
                mag = ~MOST_NEG;
            end else begin
                mag = -i_sample;
            end
        end
        abs_d[SW-2:0] = mag[SW-2:0];
        abs_valid_d   = i_sample_valid & i_enable;
    end

    assign peak_max = (abs_q > peak_q) ? abs_q : peak_q;

    // Stage 2: peak/count plus the TRACK/FLUSH control.
    always_comb begin
        state_d = i_enable ? ST_TRACK : ST_FLUSH;
        peak_d  = peak_q;
        count_d = count_q;
        amp_d   = amp_q;
        ref_d   = ref_q;
        valid_d = 1'b0;
        if (state_q == ST_FLUSH) begin
            peak_d  = '0;
            count_d = '0;
        end else if (abs_valid_q) begin
            if (count_q == {WL{1'b1}}) begin
                // A zero amplitude would make the downstream divider divide by zero.
                amp_d   = (peak_max == '0) ? AMP_ONE : peak_max;
                ref_d   = i_reference;
                valid_d = 1'b1;
                peak_d  = '0;
                count_d = '0;
            end else begin
                peak_d  = peak_max;
                count_d = count_q + WL'(1);
            end
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= ST_TRACK;
            abs_q       <= '0;
            abs_valid_q <= 1'b0;
            peak_q      <= '0;
            count_q     <= '0;
            amp_q       <= AMP_ONE;
            ref_q       <= '0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            abs_q       <= abs_d;
            abs_valid_q <= abs_valid_d;
            peak_q      <= peak_d;
            count_q     <= count_d;
            amp_q       <= amp_d;
            ref_q       <= ref_d;
            valid_q     <= valid_d;
        end
    end

    assign o_amplitude    = amp_q;
    assign o_reference    = ref_q;
    assign o_valid        = valid_q;
    assign o_window_count = count_q;

endmodule

// File: tb/tb_amplitude_peak_window.sv
// tb/tb_amplitude_peak_window.sv - self-checking bench for amplitude_peak_window
// Table-driven windows plus hand sequences for enable, close/disable overlap and reset.
module tb_amplitude_peak_window;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [15:0] sample;
    logic        sample_valid;
    logic [15:0] reference;
    logic [15:0] amplitude;
    logic [15:0] ref_out;
    logic        valid_out;
    logic [1:0]  window_count;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct {
        logic [15:0] amp;
        logic [15:0] rf;
        int          cyc;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic [15:0] s;
        logic        v;
        logic        close;
        logic [15:0] amp;
    } row_t;
    row_t tbl[$];

    amplitude_peak_window #(
        .SAMPLE_DATA_SIZE   (16),
        .AMPLITUDE_DATA_SIZE(16),
        .WINDOW_LOG2        (2)
    ) dut (
        .i_clock       (clk),
        .i_reset_n     (rst_n),
        .i_enable      (enable),
        .i_sample      (sample),
        .i_sample_valid(sample_valid),
        .i_reference   (reference),
        .o_amplitude   (amplitude),
        .o_reference   (ref_out),
        .o_valid       (valid_out),
        .o_window_count(window_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add_row(input int s, input logic v, input logic close, input int amp);
        row_t r;
        r.s     = 16'(s);
        r.v     = v;
        r.close = close;
        r.amp   = 16'(amp);
        tbl.push_back(r);
    endtask

    // Inputs change 1 time unit after a rising edge; the sample is taken at the next edge.
    task automatic drive(input int s, input logic v, input logic e, input logic close, input int amp);
        exp_t x;
        @(posedge clk);
        #1;
        sample       = 16'(s);
        sample_valid = v;
        enable       = e;
        if (close) begin
            x.amp = 16'(amp);
            x.rf  = reference;
            x.cyc = cyc + 2;
            exp_q.push_back(x);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(16'h0999, 1'b0, 1'b1, 1'b0, 0);
    endtask

    exp_t got;
    always @(negedge clk) begin
        if (rst_n && valid_out) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_pulse: got o_valid=1 at cycle %0d expected no pulse", cyc);
            end else begin
                got = exp_q.pop_front();
                check("pulse_cycle", cyc, got.cyc);
                check("o_amplitude", int'(amplitude), int'(got.amp));
                check("o_reference", int'(ref_out), int'(got.rf));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

    initial begin
        rst_n        = 1'b0;
        enable       = 1'b0;
        sample       = '0;
        sample_valid = 1'b0;
        reference    = '0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_amplitude", int'(amplitude), 1);
        check("reset_reference", int'(ref_out), 0);
        check("reset_valid", int'(valid_out), 0);
        check("reset_count", int'(window_count), 0);
        rst_n  = 1'b1;
        enable = 1'b1;
        reference = 16'h4000;
        idle(2);

        add_row(100, 1, 0, 0);
        add_row(-300, 1, 0, 0);
        add_row(200, 1, 0, 0);
        add_row(50, 1, 1, 300);
        add_row(0, 1, 0, 0);
        add_row(0, 1, 0, 0);
        add_row(0, 1, 0, 0);
        add_row(0, 1, 1, 1);
        add_row(-32768, 1, 0, 0);
        add_row(1, 1, 0, 0);
        add_row(1, 1, 0, 0);
        add_row(1, 1, 1, 32767);
        add_row(10, 1, 0, 0);
        add_row(999, 0, 0, 0);
        add_row(-999, 0, 0, 0);
        add_row(999, 0, 0, 0);
        add_row(-20, 1, 0, 0);
        add_row(999, 0, 0, 0);
        add_row(5, 1, 0, 0);
        add_row(7, 1, 1, 20);
        add_row(1, 1, 0, 0);
        add_row(2, 1, 0, 0);
        add_row(3, 1, 0, 0);
        add_row(4, 1, 1, 4);
        add_row(8, 1, 0, 0);
        add_row(7, 1, 0, 0);
        add_row(6, 1, 0, 0);
        add_row(5, 1, 1, 8);
        foreach (tbl[i]) drive(int'($signed(tbl[i].s)), tbl[i].v, 1'b1, tbl[i].close, int'(tbl[i].amp));
        idle(4);

        // Partial window discarded by disable; counter parks at 0 while disabled.
        reference = 16'h1234;
        drive(50, 1'b1, 1'b1, 1'b0, 0);
        drive(50, 1'b1, 1'b1, 1'b0, 0);
        idle(2);
        check("count_mid_window", int'(window_count), 2);
        drive(77, 1'b1, 1'b0, 1'b0, 0);
        drive(77, 1'b1, 1'b0, 1'b0, 0);
        drive(77, 1'b1, 1'b0, 1'b0, 0);
        check("count_disabled", int'(window_count), 0);
        drive(9, 1'b1, 1'b1, 1'b0, 0);
        drive(9, 1'b1, 1'b1, 1'b0, 0);
        drive(9, 1'b1, 1'b1, 1'b0, 0);
        drive(9, 1'b1, 1'b1, 1'b1, 9);
        idle(4);

        // Disable lands on the closing stage-2 cycle: that window still goes out.
        reference = 16'h2222;
        drive(33, 1'b1, 1'b1, 1'b0, 0);
        drive(-33, 1'b1, 1'b1, 1'b0, 0);
        drive(33, 1'b1, 1'b1, 1'b0, 0);
        drive(-33, 1'b1, 1'b1, 1'b1, 33);
        drive(0, 1'b0, 1'b0, 1'b0, 0);
        drive(0, 1'b0, 1'b0, 1'b0, 0);
        drive(0, 1'b0, 1'b0, 1'b0, 0);
        idle(4);

        // Asynchronous reset mid-window.
        reference = 16'h5555;
        drive(11, 1'b1, 1'b1, 1'b0, 0);
        drive(22, 1'b1, 1'b1, 1'b0, 0);
        idle(2);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_amplitude", int'(amplitude), 1);
        check("async_reference", int'(ref_out), 0);
        check("async_valid", int'(valid_out), 0);
        check("async_count", int'(window_count), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(6, 1'b1, 1'b1, 1'b0, 0);
        drive(-6, 1'b1, 1'b1, 1'b0, 0);
        drive(6, 1'b1, 1'b1, 1'b0, 0);
        idle(3);
        check("post_reset_count", int'(window_count), 3);
        drive(4, 1'b1, 1'b1, 1'b1, 6);
        idle(6);

        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/amplitude_peak_window.md
Name: amplitude_peak_window

Overview:
- Upstream stage of the divider that produces the AGC gain.
- Takes signed input samples and tracks the peak absolute amplitude over fixed windows of 2^WINDOW_LOG2 accepted samples.
- At each window end, emits a one-cycle-valid (reference, amplitude) pair that drives the divider's i_reference, i_error and i_valid inputs directly.

Parameters:
- SAMPLE_DATA_SIZE, 16, width of signed input sample (two's complement).
- AMPLITUDE_DATA_SIZE, 16, width of reference input and amplitude/reference outputs; must be >= SAMPLE_DATA_SIZE-1.
- WINDOW_LOG2, 10, log2 of window length in accepted samples (default 1024).

Ports:
- i_clock  input  1  system clock, all logic on rising edge.
- i_reset_n  input  1  asynchronous, active-low reset.
- i_enable  input  1  high = tracking active; low = hold outputs, discard partial window.
- i_sample  input  SAMPLE_DATA_SIZE  signed input sample.
- i_sample_valid  input  1  i_sample accepted this cycle when high and i_enable high.
- i_reference  input  AMPLITUDE_DATA_SIZE  target amplitude (unsigned), sampled at window close.
- o_amplitude  output  AMPLITUDE_DATA_SIZE  peak |sample| of last completed window, floor 1.
- o_reference  output  AMPLITUDE_DATA_SIZE  i_reference latched with o_amplitude.
- o_valid  output  1  one-cycle pulse: new o_amplitude/o_reference pair.
- o_window_count  output  WINDOW_LOG2  current position in window (debug/verification).

Behaviour:
- Reset (i_reset_n low, asynchronous) clears all state:
  - o_amplitude = 1, o_reference = 0, o_valid = 0, o_window_count = 0.
  - Peak register = 0, abs pipeline valid = 0.
- Stage 1 (abs), registered:
  - abs = (sample < 0) ? -sample : sample.
  - Most-negative sample (-2^(SAMPLE_DATA_SIZE-1)) saturates to 2^(SAMPLE_DATA_SIZE-1)-1.
  - Result zero-extended to AMPLITUDE_DATA_SIZE.
  - Stage valid = i_sample_valid & i_enable.
- Stage 2 (peak/count), on stage-1 valid:
  - Not the last sample of the window: peak <= max(peak, abs) and counter increments.
  - Last sample of the window (counter == 2^WINDOW_LOG2-1):
    - o_amplitude <= max(peak, abs), forced to 1 if the result is 0 (divide-by-zero guard).
    - o_reference <= i_reference (value present in this cycle).
    - o_valid <= 1.
    - peak <= 0, counter wraps to 0.
- No gap between windows: the sample whose stage-2 cycle coincides with o_valid belongs to the new window.
- Latency: last sample accepted at cycle t -> o_valid high at t+2, for exactly one cycle. o_valid is 0 in all other cycles.
- o_amplitude and o_reference hold their values between pulses. The divider captures on o_valid.
- State machine:
  - TRACK: normal operation.
  - FLUSH: entered when i_enable falls.
  - In FLUSH:
    - Stage-1 valid is cleared.
    - peak <= 0, counter <= 0.
    - No o_valid is emitted.
    - Stays in FLUSH while i_enable is low.
  - FLUSH -> TRACK on the first cycle i_enable is high; the next accepted sample is window position 0.
  - A window in progress when i_enable falls is discarded, never emitted.
- Simultaneous events:
  - i_enable falling in the cycle stage 2 closes a window: that window is still emitted (stage-2 work completes), then FLUSH.
  - i_sample_valid low mid-window: counter and peak hold; windows count accepted samples, not cycles.
- Reset mid-window: all state cleared immediately; no o_valid after reset release until a full new window completes.
- Widths: all comparisons unsigned on AMPLITUDE_DATA_SIZE; the counter is WINDOW_LOG2 bits and wraps naturally.

Test Plan:
- WINDOW_LOG2=2; samples 100, -300, 200, 50 with valid every cycle -> single o_valid 2 cycles after sample 4, o_amplitude=300, o_reference=i_reference (e.g. 0x4000).
- WINDOW_LOG2=2; window of 0,0,0,0 -> o_amplitude=1 (zero guard); next window -32768,1,1,1 -> o_amplitude=32767.
- WINDOW_LOG2=2; valid gaps: samples 10,(idle 3 cycles),-20,(idle),5,7 -> one pulse, o_amplitude=20; no pulse before the 4th accepted sample.
- Back-to-back windows 1..4 then 8,7,6,5 -> pulses exactly 4 cycles apart, amplitudes 4 then 8; peak does not carry over.
- i_enable low after 2 samples of a window, high again, then 4 samples of 9 -> only one pulse, o_amplitude=9; o_window_count=0 while disabled.
- Assert i_reset_n low for 1 cycle mid-window -> outputs return to 1/0/0 asynchronously; first pulse after release only after 4 new accepted samples.
